// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between NUM_PORTS requesters.
// Optional statistics ports are enabled by defining MEM_PORT_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned LOG_TAG_DEPTH = 4,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  localparam int unsigned REQ_W        = ADDR_W + DATA_W + 2,
  localparam int unsigned RESP_W       = DATA_W + 1,
  localparam int unsigned PORT_W       = $clog2(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  // MemReq layout: {valid, is_write, addr, data}; MemResp layout: {valid, data}
  input  logic [NUM_PORTS-1:0][REQ_W-1:0]     req_in,
  output logic [NUM_PORTS-1:0]                req_grant_out,
  output logic [NUM_PORTS-1:0][RESP_W-1:0]    resp_out,
  input  logic [NUM_PORTS-1:0]                resp_grant_in,
  output logic [REQ_W-1:0]                    mem_req_out,
  input  logic                                mem_req_grant_in,
  input  logic [RESP_W-1:0]                   mem_resp_in,
  output logic                                mem_resp_grant_out,
  output logic [LOG_TAG_DEPTH:0]              outstanding,
  output logic                                tag_err
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]          grant_count,
  output logic [LOG_TAG_DEPTH:0]              max_outstanding
`endif
);

  localparam int unsigned DEPTH = 1 << LOG_TAG_DEPTH;
  localparam logic [LOG_TAG_DEPTH:0] FULL_CNT = {1'b1, {LOG_TAG_DEPTH{1'b0}}};

  logic [PORT_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [LOG_TAG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG_TAG_DEPTH:0]   count_q, count_d;
  logic                     tag_err_q;
  logic [PORT_W-1:0]        tag_mem [DEPTH];

  logic              found, sel_write, eligible, accept, push, pop;
  logic              full, empty, tag_err_set;
  logic [PORT_W-1:0] sel, head;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < int'(NUM_PORTS); k++) begin
      automatic int idx = (int'(rr_ptr_q) + k) % int'(NUM_PORTS);
      if (!found && req_in[PORT_W'(idx)][REQ_W-1]) begin
        found = 1'b1;
        sel   = PORT_W'(idx);
      end
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign sel_write = req_in[sel][REQ_W-2];
  // A blocked read keeps the selection, so a lower-priority write cannot slip past it.
  assign eligible  = rst && found && (sel_write || !full);
  assign accept    = eligible && mem_req_grant_in;
  assign push      = accept && !sel_write;

  always_comb begin
    mem_req_out   = eligible ? req_in[sel] : '0;
    req_grant_out = '0;
    if (accept) req_grant_out[sel] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (sel == PORT_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
  end

  assign head = tag_mem[rd_ptr_q];

  always_comb begin
    resp_out           = '0;
    mem_resp_grant_out = 1'b0;
    pop                = 1'b0;
    tag_err_set        = 1'b0;
    if (rst) begin
      if (!empty) begin
        resp_out[head]     = mem_resp_in;
        mem_resp_grant_out = mem_resp_in[DATA_W] && resp_grant_in[head];
        pop                = mem_resp_grant_out;
      end else begin
        // Orphan response: drain it and flag the error.
        mem_resp_grant_out = mem_resp_in[DATA_W];
        tag_err_set        = mem_resp_in[DATA_W];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (tag_err_set) tag_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= sel;
  end

  assign outstanding = count_q;
  assign tag_err     = tag_err_q;

`ifdef MEM_PORT_ARB_STATS_EN
  logic [NUM_PORTS-1:0][31:0] grant_count_q;
  logic [LOG_TAG_DEPTH:0]     max_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_count_q <= '0;
      max_out_q     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (req_grant_out[i] && (grant_count_q[i] != '1)) begin
          grant_count_q[i] <= grant_count_q[i] + 1'b1;
        end
      end
      if (count_d > max_out_q) max_out_q <= count_d;
    end
  end

  assign grant_count     = grant_count_q;
  assign max_outstanding = max_out_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (4 ports, 16-entry tag FIFO).
module tb_mem_port_arbiter;
  localparam int NP  = 4;
  localparam int LTD = 4;
  localparam int RW  = 66;
  localparam int SW  = 33;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0][RW-1:0]  req_in;
  logic [NP-1:0]          req_grant_out;
  logic [NP-1:0][SW-1:0]  resp_out;
  logic [NP-1:0]          resp_grant_in;
  logic [RW-1:0]          mem_req_out;
  logic                   mem_req_grant_in;
  logic [SW-1:0]          mem_resp_in;
  logic                   mem_resp_grant_out;
  logic [LTD:0]           outstanding;
  logic                   tag_err;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [NP-1:0][31:0]    grant_count;
  logic [LTD:0]           max_outstanding;
`endif

  int errors = 0;
  int checks = 0;
  logic [NP-1:0][SW-1:0] exp_resp;

  mem_port_arbiter #(.NUM_PORTS(NP), .LOG_TAG_DEPTH(LTD)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_in             (req_in),
    .req_grant_out      (req_grant_out),
    .resp_out           (resp_out),
    .resp_grant_in      (resp_grant_in),
    .mem_req_out        (mem_req_out),
    .mem_req_grant_in   (mem_req_grant_in),
    .mem_resp_in        (mem_resp_in),
    .mem_resp_grant_out (mem_resp_grant_out),
    .outstanding        (outstanding),
    .tag_err            (tag_err)
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    .grant_count        (grant_count),
    .max_outstanding    (max_outstanding)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] mk_req(logic wr, logic [31:0] a, logic [31:0] d);
    return {1'b1, wr, a, d};
  endfunction

  function automatic logic [SW-1:0] mk_resp(logic [31:0] d);
    return {1'b1, d};
  endfunction

  task automatic check_eq(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b0;
    req_in           = '0;
    resp_grant_in    = '0;
    mem_req_grant_in = 1'b1;
    mem_resp_in      = mk_resp(32'd9);
    req_in[0]        = mk_req(1'b1, 32'd0, 32'd0);
    #2;
    check_eq("rst_grant", req_grant_out, '0);
    check_eq("rst_mem_req", mem_req_out, '0);
    check_eq("rst_resp_grant", mem_resp_grant_out, 1'b0);
    check_eq("rst_resp_out", resp_out, '0);
    check_eq("rst_outstanding", outstanding, '0);
    check_eq("rst_tag_err", tag_err, 1'b0);
    mem_resp_in = '0;
    #1 rst = 1'b1;

    // All four ports write continuously: strict rotation 0,1,2,3,0,...
    for (int i = 0; i < NP; i++) req_in[i] = mk_req(1'b1, 32'(i), 32'(i + 100));
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("rr_grant", req_grant_out, 256'(4'b0001 << (c % 4)));
      if (c == 0) check_eq("rr_mem_req", mem_req_out, mk_req(1'b1, 32'd0, 32'd100));
      check_eq("rr_outstanding", outstanding, '0);
      step();
    end

    // Write then read-back: port 2 writes, port 1 reads (rr_ptr = 0 then 3).
    req_in    = '0;
    req_in[2] = mk_req(1'b1, 32'd5, 32'd11);
    #1;
    check_eq("wr_mem_req", mem_req_out, mk_req(1'b1, 32'd5, 32'd11));
    check_eq("wr_grant", req_grant_out, 4'b0100);
    step();
    req_in    = '0;
    req_in[1] = mk_req(1'b0, 32'd5, 32'd0);
    #1;
    check_eq("rd_mem_req", mem_req_out, mk_req(1'b0, 32'd5, 32'd0));
    check_eq("rd_grant", req_grant_out, 4'b0010);
    step();
    req_in = '0;
    check_eq("rd_outstanding1", outstanding, 5'd1);
    mem_resp_in = mk_resp(32'd11);
    #1;
    exp_resp    = '0;
    exp_resp[1] = mk_resp(32'd11);
    check_eq("rd_resp_route", resp_out, exp_resp);
    check_eq("rd_resp_hold", mem_resp_grant_out, 1'b0);
    step();
    check_eq("rd_outstanding_held", outstanding, 5'd1);
    resp_grant_in = 4'b0010;
    #1;
    check_eq("rd_resp_grant", mem_resp_grant_out, 1'b1);
    step();
    check_eq("rd_outstanding0", outstanding, 5'd0);
    mem_resp_in   = '0;
    resp_grant_in = '0;

    // In-order delivery: port 0 reads, then port 3; port 0 stalls its response.
    req_in[0] = mk_req(1'b0, 32'd0, 32'd0);
    #1 check_eq("ord_grant0", req_grant_out, 4'b0001);
    step();
    req_in    = '0;
    req_in[3] = mk_req(1'b0, 32'd1, 32'd0);
    #1 check_eq("ord_grant3", req_grant_out, 4'b1000);
    step();
    req_in = '0;
    check_eq("ord_outstanding2", outstanding, 5'd2);
    mem_resp_in   = mk_resp(32'd1);
    resp_grant_in = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_eq("ord_stall_grant", mem_resp_grant_out, 1'b0);
      check_eq("ord_p3_not_valid", resp_out[3][SW-1], 1'b0);
      check_eq("ord_p0_resp", resp_out[0], mk_resp(32'd1));
      step();
    end
    resp_grant_in = 4'b1001;
    #1 check_eq("ord_p0_grant", mem_resp_grant_out, 1'b1);
    step();
    check_eq("ord_outstanding1", outstanding, 5'd1);
    mem_resp_in = mk_resp(32'd3);
    #1;
    check_eq("ord_p3_resp", resp_out[3], mk_resp(32'd3));
    check_eq("ord_p0_idle", resp_out[0], '0);
    check_eq("ord_p3_grant", mem_resp_grant_out, 1'b1);
    step();
    check_eq("ord_outstanding0", outstanding, 5'd0);
    mem_resp_in   = '0;
    resp_grant_in = '0;

    // Fill the tag FIFO with 16 reads from port 1 (rr_ptr = 0).
    req_in[1] = mk_req(1'b0, 32'h10, 32'd0);
    for (int c = 0; c < 16; c++) begin
      #1 check_eq("fill_grant", req_grant_out, 4'b0010);
      step();
    end
    check_eq("full_outstanding", outstanding, 5'd16);
`ifdef MEM_PORT_ARB_STATS_EN
    check_eq("stats_max16", max_outstanding, 5'd16);
`endif
    // rr_ptr = 2: port 2 read is selected but blocked; port 3 write must wait too.
    req_in    = '0;
    req_in[2] = mk_req(1'b0, 32'd7, 32'd0);
    req_in[3] = mk_req(1'b1, 32'd8, 32'd8);
    #1;
    check_eq("full_no_grant", req_grant_out, '0);
    check_eq("full_mem_req", mem_req_out, '0);
    step();
    check_eq("full_still16", outstanding, 5'd16);
    mem_resp_in   = mk_resp(32'd5);
    resp_grant_in = '1;
    #1;
    check_eq("full_pop_no_push", req_grant_out, '0);
    check_eq("full_pop_grant", mem_resp_grant_out, 1'b1);
    step();
    check_eq("after_pop15", outstanding, 5'd15);
    #1;
    check_eq("pushpop_grant", req_grant_out, 4'b0100);
    check_eq("pushpop_mem_req", mem_req_out, mk_req(1'b0, 32'd7, 32'd0));
    step();
    check_eq("pushpop_outstanding", outstanding, 5'd15);
    req_in = '0;
    for (int c = 0; c < 14; c++) step();
    #1 check_eq("last_tag_route", resp_out[2], mk_resp(32'd5));
    check_eq("drain_outstanding1", outstanding, 5'd1);
    step();
    mem_resp_in   = '0;
    resp_grant_in = '0;
    check_eq("drain_outstanding0", outstanding, 5'd0);
    check_eq("drain_tag_err", tag_err, 1'b0);

    // Orphan response with nothing outstanding.
    mem_resp_in = mk_resp(32'd7);
    #1;
    check_eq("orphan_grant", mem_resp_grant_out, 1'b1);
    check_eq("orphan_resp_out", resp_out, '0);
    step();
    mem_resp_in = '0;
    check_eq("orphan_tag_err", tag_err, 1'b1);
    step();
    check_eq("orphan_sticky", tag_err, 1'b1);

    // Three reads outstanding with rr_ptr ending at 2, then asynchronous reset.
    for (int p = 0; p < 3; p++) begin
      automatic int port = (p + 3) % NP;
      req_in       = '0;
      req_in[port] = mk_req(1'b0, 32'(p), 32'd0);
      #1 check_eq("pre_rst_grant", req_grant_out, 256'(4'b0001 << port));
      step();
    end
    for (int i = 0; i < NP; i++) req_in[i] = mk_req(1'b1, 32'(i), 32'd0);
    check_eq("pre_rst_outstanding", outstanding, 5'd3);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_outstanding", outstanding, '0);
    check_eq("arst_tag_err", tag_err, 1'b0);
    check_eq("arst_grant", req_grant_out, '0);
    check_eq("arst_mem_req", mem_req_out, '0);
`ifdef MEM_PORT_ARB_STATS_EN
    check_eq("arst_grant_count", grant_count, '0);
    check_eq("arst_max_out", max_outstanding, '0);
`endif
    #1 rst = 1'b1;
    #1 check_eq("arst_rr_ptr0", req_grant_out, 4'b0001);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
